// File: rtl/regdst_pkg.sv
// rtl/regdst_pkg.sv - command, selector and state encodings for the write-back sequencer
package regdst_pkg;

  localparam logic [2:0] CMD_WB_RT = 3'd0;
  localparam logic [2:0] CMD_WB_RD = 3'd1;
  localparam logic [2:0] CMD_WB_RS = 3'd2;
  localparam logic [2:0] CMD_LINK  = 3'd3;
  localparam logic [2:0] CMD_PUSH  = 3'd4;
  localparam logic [2:0] CMD_POP   = 3'd5;

  localparam logic [2:0] SEL_RT = 3'b000;
  localparam logic [2:0] SEL_RD = 3'b001;
  localparam logic [2:0] SEL_RS = 3'b010;
  localparam logic [2:0] SEL_SP = 3'b011;
  localparam logic [2:0] SEL_RA = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_SPDEC, S_MEMWR, S_MEMRD, S_POPWB, S_SPINC, S_ERR
  } state_e;

  // Destination select for the single-cycle write-back commands.
  function automatic logic [2:0] wb_sel(input logic [2:0] c);
    case (c)
      CMD_WB_RD: wb_sel = SEL_RD;
      CMD_WB_RS: wb_sel = SEL_RS;
      CMD_LINK:  wb_sel = SEL_RA;
      default:   wb_sel = SEL_RT;
    endcase
  endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - memory access cycle counter; last flags the final cycle of an access
module wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [3:0] limit,
  output logic       last
);

  logic [3:0] count;

  assign last = (count == limit - 4'd1);

  // Saturates at limit-1 so a stalled exit can never wrap the count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 4'd0;
    end else if (en && !last) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/regdst_sequencer.sv
// rtl/regdst_sequencer.sv - multicycle controller for register write-back, link, push and pop
module regdst_sequencer
  import regdst_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] cmd,
  output logic [2:0] reg_dst_sel,
  output logic       reg_write,
  output logic       sp_dec,
  output logic       sp_inc,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mdr_load,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] LIMIT = 4'(MEM_WAIT);

  state_e     state, state_nxt;
  logic [2:0] cmd_q;
  logic       cnt_en;
  logic       cnt_last;

  assign cnt_en = (state == S_MEMRD) || (state == S_MEMWR);

  // Held clear outside the memory states, so every access starts from zero.
  wait_counter u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!cnt_en),
    .en    (cnt_en),
    .limit (LIMIT),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cmd_q <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        cmd_q <= cmd;
      end
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (cmd)
            CMD_WB_RT, CMD_WB_RD, CMD_WB_RS, CMD_LINK: state_nxt = S_WB;
            CMD_PUSH: state_nxt = S_SPDEC;
            CMD_POP:  state_nxt = S_MEMRD;
            default:  state_nxt = S_ERR;
          endcase
        end
      end
      S_SPDEC: state_nxt = S_MEMWR;
      S_MEMWR: state_nxt = cnt_last ? S_IDLE : S_MEMWR;
      S_MEMRD: state_nxt = cnt_last ? S_POPWB : S_MEMRD;
      S_POPWB: state_nxt = S_SPINC;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reg_dst_sel = SEL_RT;
    reg_write   = 1'b0;
    sp_dec      = 1'b0;
    sp_inc      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mdr_load    = 1'b0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_WB: begin
        reg_dst_sel = wb_sel(cmd_q);
        reg_write   = 1'b1;
        done        = 1'b1;
      end
      S_SPDEC: begin
        reg_dst_sel = SEL_SP;
        reg_write   = 1'b1;
        sp_dec      = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        done      = cnt_last;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        mdr_load = cnt_last;
      end
      S_POPWB: begin
        reg_write = 1'b1;
      end
      S_SPINC: begin
        reg_dst_sel = SEL_SP;
        reg_write   = 1'b1;
        sp_inc      = 1'b1;
        done        = 1'b1;
      end
      S_ERR: begin
        err  = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regdst_sequencer.sv
// tb/tb_regdst_sequencer.sv - scoreboard bench for regdst_sequencer at MEM_WAIT=2 and MEM_WAIT=1
module tb_regdst_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [2:0] cmd_a = 3'd0, cmd_b = 3'd0;

  logic [2:0] sel_a, sel_b;
  logic rw_a, dec_a, inc_a, rd_a, wr_a, mdr_a, busy_a, done_a, err_a;
  logic rw_b, dec_b, inc_b, rd_b, wr_b, mdr_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  regdst_sequencer #(.MEM_WAIT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cmd(cmd_a),
    .reg_dst_sel(sel_a), .reg_write(rw_a), .sp_dec(dec_a), .sp_inc(inc_a),
    .mem_read(rd_a), .mem_write(wr_a), .mdr_load(mdr_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  regdst_sequencer #(.MEM_WAIT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cmd(cmd_b),
    .reg_dst_sel(sel_b), .reg_write(rw_b), .sp_dec(dec_b), .sp_inc(inc_b),
    .mem_read(rd_b), .mem_write(wr_b), .mdr_load(mdr_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  logic [11:0] out_a, out_b;
  assign out_a = {sel_a, rw_a, dec_a, inc_a, rd_a, wr_a, mdr_a, busy_a, done_a, err_a};
  assign out_b = {sel_b, rw_b, dec_b, inc_b, rd_b, wr_b, mdr_b, busy_b, done_b, err_b};

  typedef struct {
    bit          which;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] IDLE = 12'd0;

  function automatic logic [11:0] ev(input logic [2:0] s, input logic rw, input logic dec,
                                     input logic inc, input logic rd, input logic wr,
                                     input logic mdr, input logic bsy, input logic dn,
                                     input logic er);
    ev = {s, rw, dec, inc, rd, wr, mdr, bsy, dn, er};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input bit which, input logic st, input logic [2:0] c, input logic rst,
                     input logic [11:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst;
    start_a = 1'b0;
    start_b = 1'b0;
    if (which) begin
      start_b = st;
      cmd_b = c;
    end else begin
      start_a = st;
      cmd_a = c;
    end
    e.which = which;
    e.exp = exp;
    e.name = nm;
    sbq.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [11:0] act;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = e.which ? out_b : out_a;
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %b expected %b (sel,rw,dec,inc,rd,wr,mdr,busy,done,err)",
                   e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    cyc(0, 0, 3'd0, 1, IDLE, "reset");
    for (int i = 0; i < 5; i++) cyc(0, 0, 3'd0, 0, IDLE, "idle_after_reset");

    cyc(0, 1, 3'd3, 0, ev(3'b100, 1, 0, 0, 0, 0, 0, 1, 1, 0), "link_wb");
    cyc(0, 0, 3'd0, 0, IDLE, "link_idle");

    cyc(0, 1, 3'd4, 0, ev(3'b011, 1, 1, 0, 0, 0, 0, 1, 0, 0), "push_spdec");
    cyc(0, 0, 3'd0, 0, ev(3'b000, 0, 0, 0, 0, 1, 0, 1, 0, 0), "push_memwr1");
    cyc(0, 0, 3'd0, 0, ev(3'b000, 0, 0, 0, 0, 1, 0, 1, 1, 0), "push_memwr2_done");
    cyc(0, 0, 3'd0, 0, IDLE, "push_idle");

    cyc(0, 1, 3'd5, 0, ev(3'b000, 0, 0, 0, 1, 0, 0, 1, 0, 0), "pop_memrd1");
    cyc(0, 1, 3'd1, 0, ev(3'b000, 0, 0, 0, 1, 0, 1, 1, 0, 0), "pop_memrd2_mdr");
    cyc(0, 1, 3'd1, 0, ev(3'b000, 1, 0, 0, 0, 0, 0, 1, 0, 0), "pop_wb");
    cyc(0, 1, 3'd1, 0, ev(3'b011, 1, 0, 1, 0, 0, 0, 1, 1, 0), "pop_spinc_done");
    cyc(0, 1, 3'd1, 0, IDLE, "pop_start_in_done_ignored");
    cyc(0, 0, 3'd0, 0, IDLE, "pop_idle");

    cyc(0, 1, 3'd7, 0, ev(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 1), "illegal7_err");
    cyc(0, 0, 3'd0, 0, IDLE, "illegal7_idle");
    cyc(0, 1, 3'd6, 0, ev(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 1), "illegal6_err");
    cyc(0, 0, 3'd0, 0, IDLE, "illegal6_idle");

    cyc(0, 1, 3'd0, 0, ev(3'b000, 1, 0, 0, 0, 0, 0, 1, 1, 0), "wb_rt");
    cyc(0, 1, 3'd2, 0, IDLE, "wb_rt_start_in_done_ignored");
    cyc(0, 1, 3'd2, 0, ev(3'b010, 1, 0, 0, 0, 0, 0, 1, 1, 0), "wb_rs");
    cyc(0, 0, 3'd0, 0, IDLE, "wb_rs_idle");

    cyc(0, 1, 3'd4, 0, ev(3'b011, 1, 1, 0, 0, 0, 0, 1, 0, 0), "push2_spdec");
    cyc(0, 0, 3'd0, 0, ev(3'b000, 0, 0, 0, 0, 1, 0, 1, 0, 0), "push2_memwr1");
    cyc(0, 0, 3'd0, 1, IDLE, "push2_reset_abort");
    cyc(0, 0, 3'd0, 0, IDLE, "push2_after_reset1");
    cyc(0, 0, 3'd0, 0, IDLE, "push2_after_reset2");

    cyc(1, 1, 3'd5, 0, ev(3'b000, 0, 0, 0, 1, 0, 1, 1, 0, 0), "w1_pop_memrd");
    cyc(1, 0, 3'd0, 0, ev(3'b000, 1, 0, 0, 0, 0, 0, 1, 0, 0), "w1_pop_wb");
    cyc(1, 0, 3'd0, 0, ev(3'b011, 1, 0, 1, 0, 0, 0, 1, 1, 0), "w1_pop_spinc_done");
    cyc(1, 0, 3'd0, 0, IDLE, "w1_idle");
    cyc(1, 1, 3'd1, 0, ev(3'b001, 1, 0, 0, 0, 0, 0, 1, 1, 0), "w1_wb_rd");
    cyc(1, 0, 3'd0, 0, IDLE, "w1_final_idle");

    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
